// File: rtl/dmr_response_fanout.sv
// dmr_response_fanout: gates compared OBI requests per bus and fans the single response out to all lockstep harts
module dmr_response_fanout #(
  parameter int NHARTS          = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   compared_instr_req_i,
  input  logic                   compared_instr_we_i,
  input  logic [3:0]             compared_instr_be_i,
  input  logic [31:0]            compared_instr_addr_i,
  input  logic [31:0]            compared_instr_wdata_i,
  output logic                   bus_instr_req_o,
  output logic                   bus_instr_we_o,
  output logic [3:0]             bus_instr_be_o,
  output logic [31:0]            bus_instr_addr_o,
  output logic [31:0]            bus_instr_wdata_o,
  input  logic                   bus_instr_gnt_i,
  input  logic                   bus_instr_rvalid_i,
  input  logic [31:0]            bus_instr_rdata_i,
  output logic [NHARTS-1:0]      core_instr_gnt_o,
  output logic [NHARTS-1:0]      core_instr_rvalid_o,
  output logic [NHARTS*32-1:0]   core_instr_rdata_o,
  input  logic                   compared_data_req_i,
  input  logic                   compared_data_we_i,
  input  logic [3:0]             compared_data_be_i,
  input  logic [31:0]            compared_data_addr_i,
  input  logic [31:0]            compared_data_wdata_i,
  output logic                   bus_data_req_o,
  output logic                   bus_data_we_o,
  output logic [3:0]             bus_data_be_o,
  output logic [31:0]            bus_data_addr_o,
  output logic [31:0]            bus_data_wdata_o,
  input  logic                   bus_data_gnt_i,
  input  logic                   bus_data_rvalid_i,
  input  logic [31:0]            bus_data_rdata_i,
  output logic [NHARTS-1:0]      core_data_gnt_o,
  output logic [NHARTS-1:0]      core_data_rvalid_o,
  output logic [NHARTS*32-1:0]   core_data_rdata_o,
  input  logic                   error_i,
  input  logic                   clear_i,
  output logic                   fault_o,
  output logic                   timeout_o,
  output logic                   spurious_o
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [1:0] {RUN, DRAIN, FAULT} state_e;
  state_e        state_q, state_d;
  logic [CW-1:0] icnt_q, icnt_d, dcnt_q, dcnt_d;
  logic [TW-1:0] itmr_q, itmr_d, dtmr_q, dtmr_d;
  logic          timeout_q, timeout_d, spurious_q, spurious_d;
  logic          ipass, dpass, iinc, dinc, idec, ddec, ihit, dhit, to_ev, sp_ev;
  // request gating: forward only while running, error-free and below the outstanding limit
  always_comb begin
    ipass             = (state_q == RUN) && !error_i && (icnt_q < CW'(MAX_OUTSTANDING));
    dpass             = (state_q == RUN) && !error_i && (dcnt_q < CW'(MAX_OUTSTANDING));
    bus_instr_req_o   = ipass & compared_instr_req_i;
    bus_instr_we_o    = ipass & compared_instr_we_i;
    bus_instr_be_o    = ipass ? compared_instr_be_i : '0;
    bus_instr_addr_o  = ipass ? compared_instr_addr_i : '0;
    bus_instr_wdata_o = ipass ? compared_instr_wdata_i : '0;
    bus_data_req_o    = dpass & compared_data_req_i;
    bus_data_we_o     = dpass & compared_data_we_i;
    bus_data_be_o     = dpass ? compared_data_be_i : '0;
    bus_data_addr_o   = dpass ? compared_data_addr_i : '0;
    bus_data_wdata_o  = dpass ? compared_data_wdata_i : '0;
  end
  // response fan-out: grants only in RUN, in-flight data still delivered while draining
  always_comb begin
    core_instr_gnt_o    = {NHARTS{(state_q == RUN) & bus_instr_gnt_i}};
    core_instr_rvalid_o = {NHARTS{(state_q != FAULT) & bus_instr_rvalid_i}};
    core_instr_rdata_o  = (state_q != FAULT) ? {NHARTS{bus_instr_rdata_i}} : '0;
    core_data_gnt_o     = {NHARTS{(state_q == RUN) & bus_data_gnt_i}};
    core_data_rvalid_o  = {NHARTS{(state_q != FAULT) & bus_data_rvalid_i}};
    core_data_rdata_o   = (state_q != FAULT) ? {NHARTS{bus_data_rdata_i}} : '0;
  end
  // outstanding counters, stall timers and anomaly detection
  always_comb begin
    iinc   = bus_instr_req_o & bus_instr_gnt_i;
    dinc   = bus_data_req_o & bus_data_gnt_i;
    idec   = bus_instr_rvalid_i & (icnt_q != '0);
    ddec   = bus_data_rvalid_i & (dcnt_q != '0);
    ihit   = (icnt_q != '0) & !bus_instr_rvalid_i & (itmr_q == TW'(TIMEOUT_CYCLES - 1));
    dhit   = (dcnt_q != '0) & !bus_data_rvalid_i & (dtmr_q == TW'(TIMEOUT_CYCLES - 1));
    to_ev  = ihit | dhit;
    sp_ev  = (bus_instr_rvalid_i & (icnt_q == '0)) | (bus_data_rvalid_i & (dcnt_q == '0));
    icnt_d = to_ev ? '0 : icnt_q + CW'(iinc) - CW'(idec);
    dcnt_d = to_ev ? '0 : dcnt_q + CW'(dinc) - CW'(ddec);
    itmr_d = (to_ev | bus_instr_rvalid_i | (icnt_q == '0)) ? '0 : itmr_q + TW'(1);
    dtmr_d = (to_ev | bus_data_rvalid_i | (dcnt_q == '0)) ? '0 : dtmr_q + TW'(1);
  end
  // state machine and sticky cause flags; flags only latch outside FAULT and clear on recovery
  always_comb begin
    state_d    = state_q;
    timeout_d  = timeout_q | ((state_q != FAULT) & to_ev);
    spurious_d = spurious_q | ((state_q != FAULT) & sp_ev);
    case (state_q)
      RUN:     state_d = (to_ev | sp_ev) ? FAULT : error_i ? DRAIN : RUN;
      DRAIN:   state_d = (to_ev | sp_ev | ((icnt_d == '0) & (dcnt_d == '0))) ? FAULT : DRAIN;
      FAULT: begin
        state_d    = (clear_i & !error_i) ? RUN : FAULT;
        timeout_d  = (clear_i & !error_i) ? 1'b0 : timeout_q;
        spurious_d = (clear_i & !error_i) ? 1'b0 : spurious_q;
      end
      default: state_d = RUN;
    endcase
  end
  // state register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      icnt_q     <= '0;
      dcnt_q     <= '0;
      itmr_q     <= '0;
      dtmr_q     <= '0;
      timeout_q  <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      icnt_q     <= icnt_d;
      dcnt_q     <= dcnt_d;
      itmr_q     <= itmr_d;
      dtmr_q     <= dtmr_d;
      timeout_q  <= timeout_d;
      spurious_q <= spurious_d;
    end
  end
  assign fault_o    = (state_q == FAULT);
  assign timeout_o  = timeout_q;
  assign spurious_o = spurious_q;
endmodule

// File: tb/tb_dmr_response_fanout.sv
// tb_dmr_response_fanout: random and directed stimulus against a queue-based reference model with a response scoreboard
module tb_dmr_response_fanout;
  localparam int NH = 2;
  localparam int MAXO = 2;
  localparam int T = 1024;
  localparam int M_RUN = 0, M_DRAIN = 1, M_FAULT = 2;
  logic clk, rst_n, err, clr;
  logic [1:0] c_req, c_we, gnt, rv, b_req, b_we;
  logic [3:0] c_be[2], b_be[2];
  logic [31:0] c_addr[2], c_wdata[2], rdata[2], b_addr[2], b_wdata[2];
  logic [NH-1:0] cg[2], crv[2];
  logic [NH*32-1:0] crd[2];
  logic fault_o, timeout_o, spurious_o;
  int total = 0, bad = 0;
  bit chk_en = 0;
  int st, n[2], idle[2];
  bit tflag, sflag;
  logic [31:0] pend[2][$];
  logic [31:0] eq[2][$];
  dmr_response_fanout #(.NHARTS(NH), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .compared_instr_req_i(c_req[0]), .compared_instr_we_i(c_we[0]), .compared_instr_be_i(c_be[0]),
    .compared_instr_addr_i(c_addr[0]), .compared_instr_wdata_i(c_wdata[0]),
    .bus_instr_req_o(b_req[0]), .bus_instr_we_o(b_we[0]), .bus_instr_be_o(b_be[0]),
    .bus_instr_addr_o(b_addr[0]), .bus_instr_wdata_o(b_wdata[0]),
    .bus_instr_gnt_i(gnt[0]), .bus_instr_rvalid_i(rv[0]), .bus_instr_rdata_i(rdata[0]),
    .core_instr_gnt_o(cg[0]), .core_instr_rvalid_o(crv[0]), .core_instr_rdata_o(crd[0]),
    .compared_data_req_i(c_req[1]), .compared_data_we_i(c_we[1]), .compared_data_be_i(c_be[1]),
    .compared_data_addr_i(c_addr[1]), .compared_data_wdata_i(c_wdata[1]),
    .bus_data_req_o(b_req[1]), .bus_data_we_o(b_we[1]), .bus_data_be_o(b_be[1]),
    .bus_data_addr_o(b_addr[1]), .bus_data_wdata_o(b_wdata[1]),
    .bus_data_gnt_i(gnt[1]), .bus_data_rvalid_i(rv[1]), .bus_data_rdata_i(rdata[1]),
    .core_data_gnt_o(cg[1]), .core_data_rvalid_o(crv[1]), .core_data_rdata_o(crd[1]),
    .error_i(err), .clear_i(clr), .fault_o(fault_o), .timeout_o(timeout_o), .spurious_o(spurious_o)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [127:0] a, logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  task automatic quiet();
    c_req = 0; c_we = 0; gnt = 0; rv = 0; err = 0; clr = 0;
    for (int b = 0; b < 2; b++) begin
      c_be[b] = 0; c_addr[b] = 0; c_wdata[b] = 0; rdata[b] = 0;
    end
  endtask
  task automatic model_reset();
    st = M_RUN; tflag = 0; sflag = 0;
    for (int b = 0; b < 2; b++) begin
      n[b] = 0; idle[b] = 0; pend[b].delete();
    end
  endtask
  // one clock: inputs already driven at negedge; check outputs, advance the model, wait for next negedge
  task automatic cyc();
    bit pass[2], tick[2], to[2], sp[2];
    int nn[2];
    bit anyto, anysp;
    logic [69:0] ev;
    #1;
    for (int b = 0; b < 2; b++) begin
      pass[b] = (st == M_RUN) && !err && (n[b] < MAXO);
      ev = pass[b] ? {c_req[b], c_we[b], c_be[b], c_addr[b], c_wdata[b]} : 70'd0;
      if (chk_en) begin
        chk(b ? "dreq" : "ireq", {b_req[b], b_we[b], b_be[b], b_addr[b], b_wdata[b]}, ev);
        chk(b ? "dgnt_fan" : "ignt_fan", cg[b], (st == M_RUN) ? {NH{gnt[b]}} : '0);
        if (st != M_FAULT && rv[b]) eq[b].push_back(rdata[b]);
      end
    end
    if (chk_en) begin
      chk("fault", fault_o, st == M_FAULT);
      chk("timeout_flag", timeout_o, tflag);
      chk("spurious_flag", spurious_o, sflag);
    end
    for (int b = 0; b < 2; b++) begin
      tick[b] = n[b] > 0 && !rv[b];
      to[b] = tick[b] && idle[b] == T - 1;
      sp[b] = rv[b] && n[b] == 0;
    end
    anyto = to[0] | to[1];
    anysp = sp[0] | sp[1];
    for (int b = 0; b < 2; b++) begin
      if (rv[b] && pend[b].size() != 0) void'(pend[b].pop_front());
      if (pass[b] && c_req[b] && gnt[b]) pend[b].push_back($urandom);
      nn[b] = anyto ? 0 : n[b] + int'(pass[b] && c_req[b] && gnt[b]) - int'(rv[b] && n[b] > 0);
      idle[b] = (anyto || !tick[b]) ? 0 : idle[b] + 1;
      if (anyto) pend[b].delete();
    end
    if (st != M_FAULT) begin
      tflag |= anyto;
      sflag |= anysp;
    end
    if (st == M_RUN) st = (anyto || anysp) ? M_FAULT : err ? M_DRAIN : M_RUN;
    else if (st == M_DRAIN) st = (anyto || anysp || (nn[0] == 0 && nn[1] == 0)) ? M_FAULT : M_DRAIN;
    else if (clr && !err) begin
      st = M_RUN; tflag = 0; sflag = 0;
    end
    n = nn;
    if (!rst_n) model_reset();
    @(negedge clk);
  endtask
  // scoreboard monitor: every replicated rvalid must match the oldest expected response on that bus
  always @(negedge clk) begin
    logic [31:0] e;
    #4;
    if (chk_en) for (int b = 0; b < 2; b++) begin
      if (crv[b] != 0 || eq[b].size() != 0) begin
        if (eq[b].size() == 0) chk(b ? "drv_unexpected" : "irv_unexpected", crv[b], 0);
        else begin
          e = eq[b].pop_front();
          chk(b ? "drsp" : "irsp", {crv[b], crd[b]}, {{NH{1'b1}}, {NH{e}}});
        end
      end
    end
  end
  initial begin
    rst_n = 0;
    quiet();
    model_reset();
    @(negedge clk);
    cyc();
    chk_en = 1;
    cyc();
    rst_n = 1;
    // single data read: grant in cycle 1, response in cycle 3
    quiet(); c_req[1] = 1; c_addr[1] = 32'h100; gnt[1] = 1;
    #1; chk("read_gnt_fan", cg[1], {NH{1'b1}});
    cyc();
    quiet(); cyc();
    rv[1] = 1; rdata[1] = 32'hDEADBEEF; cyc();
    quiet(); #1; chk("read_no_fault", fault_o, 0); cyc();
    // back-to-back instruction reads hit the outstanding limit
    c_req[0] = 1; c_addr[0] = 32'h200; gnt[0] = 1; cyc();
    c_addr[0] = 32'h204; cyc();
    c_addr[0] = 32'h208; #1; chk("third_gated", b_req[0], 0); cyc();
    rv[0] = 1; rdata[0] = 32'h11; #1; chk("gated_during_rv", b_req[0], 0); cyc();
    rv[0] = 0; #1; chk("fwd_after_rv", b_req[0], 1); cyc();
    quiet(); rv[0] = 1; rdata[0] = 32'h22; cyc();
    rdata[0] = 32'h33; cyc();
    quiet(); cyc();
    // error with one data read in flight: drain then fault
    c_req[1] = 1; gnt[1] = 1; cyc();
    quiet(); err = 1; cyc();
    c_req[1] = 1; gnt[1] = 1; rv[1] = 1; rdata[1] = 32'h5A5A;
    #1; chk("drain_gated", b_req[1], 0); chk("drain_gnt_zero", cg[1], 0);
    cyc();
    quiet(); #1; chk("drain_to_fault", fault_o, 1); cyc();
    clr = 1; cyc();
    quiet(); cyc();
    // instruction read never answered: timeout
    c_req[0] = 1; gnt[0] = 1; cyc();
    quiet();
    repeat (T) cyc();
    #1; chk("to_fault", fault_o, 1); chk("to_flag", timeout_o, 1);
    rv[1] = 1; rdata[1] = 32'hBAD;
    #1; chk("fault_resp_zero", {cg[0], cg[1], crv[0], crv[1], crd[0], crd[1]}, 0);
    cyc();
    quiet(); clr = 1; cyc();
    quiet(); c_req[0] = 1; gnt[0] = 1; cyc();
    #1; chk("cnt_cleared_fwd", b_req[0], 1); cyc();
    quiet(); rv[0] = 1; rdata[0] = 32'h44; cyc(); rdata[0] = 32'h55; cyc();
    // spurious response, then clear with and without error
    quiet(); rv[1] = 1; rdata[1] = 32'h77; cyc();
    quiet(); #1; chk("sp_flag", spurious_o, 1); chk("sp_fault", fault_o, 1);
    clr = 1; err = 1; cyc();
    quiet(); #1; chk("clr_err_hold", fault_o, 1);
    clr = 1; cyc();
    quiet(); #1; chk("clr_run", fault_o, 0); chk("clr_sp_flag", spurious_o, 0); cyc();
    // reset while draining, then a late response counts as spurious
    c_req[1] = 1; gnt[1] = 1; cyc();
    quiet(); err = 1; cyc();
    quiet(); rst_n = 0; cyc();
    rst_n = 1; #1; chk("rst_run", fault_o, 0);
    c_req[1] = 1; gnt[1] = 1; cyc(); cyc();
    quiet(); rv[1] = 1; rdata[1] = 32'h66; cyc(); rdata[1] = 32'h67; cyc();
    rdata[1] = 32'h68; cyc();
    quiet(); #1; chk("late_rv_spurious", spurious_o, 1);
    clr = 1; cyc();
    quiet(); cyc();
    // randomized traffic with occasional errors, spurious responses, clears and resets
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 2; b++) begin
        c_req[b] = 1'($urandom); c_we[b] = 1'($urandom); c_be[b] = 4'($urandom);
        c_addr[b] = $urandom; c_wdata[b] = $urandom;
        gnt[b] = ($urandom % 4) != 0;
        rv[b] = 0; rdata[b] = $urandom;
        if (pend[b].size() != 0 && $urandom % 3 == 0) begin
          rv[b] = 1; rdata[b] = pend[b][0];
        end else if ($urandom % 150 == 0) rv[b] = 1;
      end
      err = ($urandom % 60) == 0;
      clr = (st == M_FAULT) && ($urandom % 6 == 0);
      if (clr) err = ($urandom % 3) == 0;
      rst_n = ($urandom % 700) != 0;
      cyc();
    end
    rst_n = 1; quiet(); cyc(); cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
